// File: rtl/uart_bus_bridge_if.sv
// Peripheral bus between the UART bridge (master) and the register-mapped peripherals (slave).
// Read data is combinational from the slave while cs && oe.
interface uart_bus_bridge_if;
   logic        bus_req;
   logic        bus_gnt;
   logic        cs;
   logic        oe;
   logic [3:0]  wstrb;
   logic [5:0]  addr;
   logic [31:0] data_out;
   logic [31:0] data_in;

   modport master (
      output bus_req, cs, oe, wstrb, addr, data_out,
      input  bus_gnt, data_in
   );

   modport slave (
      input  bus_req, cs, oe, wstrb, addr, data_out,
      output bus_gnt, data_in
   );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART (8N1) command bridge: 'R' addr -> 4-byte read reply, 'W' addr strb d0..d3 -> ACK,
// anything else -> NAK. One bus access per command, gated by bus_req/bus_gnt.
module uart_bus_bridge #(
   parameter logic [15:0] BRR     = 16'd433,
   parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   output logic txd,
   uart_bus_bridge_if.master bus
);

   localparam logic [31:0] HALF32  = (32'(BRR) + 32'd1) >> 1;
   localparam logic [15:0] HALF_M1 = (HALF32 == 32'd0) ? 16'd0 : 16'(HALF32 - 32'd1);

   typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_STRB, GET_DATA, REQ, ACCESS, RESP, WAIT_TX} state_t;

   logic        rxd_s1, rxd_s2, rxd_prev;
   rx_state_t   rx_state;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_valid;
   logic [7:0]  rx_byte;

   logic        tx_load;
   logic [7:0]  tx_data;
   logic        tx_active;
   logic [8:0]  tx_shift;
   logic [3:0]  tx_bit;
   logic [15:0] tx_cnt;
   logic        tx_done;

   state_t      state;
   logic        is_read;
   logic [5:0]  addr_r;
   logic [3:0]  strb_r;
   logic [31:0] wdata;
   logic [1:0]  byte_cnt;
   logic [19:0] idle_cnt;
   logic [31:0] resp_word;

   // Receiver: a false start or a zero stop bit simply drops back to hunting.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_s1   <= 1'b1;
         rxd_s2   <= 1'b1;
         rxd_prev <= 1'b1;
         rx_state <= RX_HUNT;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
      end else begin
         rxd_s1   <= rxd;
         rxd_s2   <= rxd_s1;
         rxd_prev <= rxd_s2;
         rx_valid <= 1'b0;
         case (rx_state)
            RX_HUNT: begin
               if (rxd_prev && !rxd_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_M1) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rxd_s2 ? RX_HUNT : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BRR) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rxd_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BRR) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_HUNT;
                  if (rxd_s2) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= rx_shift;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_HUNT;
         endcase
      end
   end

   // Transmitter: tx_done pulses the cycle after the stop bit has been fully sent.
   always_ff @(posedge clk) begin
      if (rst) begin
         txd       <= 1'b1;
         tx_active <= 1'b0;
         tx_shift  <= '1;
         tx_bit    <= '0;
         tx_cnt    <= '0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!tx_active) begin
            if (tx_load) begin
               txd       <= 1'b0;
               tx_shift  <= {1'b1, tx_data};
               tx_bit    <= '0;
               tx_cnt    <= '0;
               tx_active <= 1'b1;
            end
         end else if (tx_cnt == BRR) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_active <= 1'b0;
               tx_done   <= 1'b1;
               txd       <= 1'b1;
            end else begin
               txd      <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
               tx_bit   <= tx_bit + 4'd1;
            end
         end else begin
            tx_cnt <= tx_cnt + 16'd1;
         end
      end
   end

   // Command FSM; every bus output is a register so cs/oe/wstrb are clean one-cycle strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         is_read      <= 1'b0;
         addr_r       <= '0;
         strb_r       <= '0;
         wdata        <= '0;
         byte_cnt     <= '0;
         idle_cnt     <= '0;
         resp_word    <= '0;
         tx_load      <= 1'b0;
         tx_data      <= '0;
         bus.bus_req  <= 1'b0;
         bus.cs       <= 1'b0;
         bus.oe       <= 1'b0;
         bus.wstrb    <= '0;
         bus.addr     <= '0;
         bus.data_out <= '0;
      end else begin
         tx_load <= 1'b0;
         if (state != GET_ADDR && state != GET_STRB && state != GET_DATA) idle_cnt <= '0;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_byte == 8'h52 || rx_byte == 8'h57) begin
                     is_read <= (rx_byte == 8'h52);
                     state   <= GET_ADDR;
                  end else if (!tx_active && !tx_load) begin
                     tx_load <= 1'b1;
                     tx_data <= 8'h15;
                  end
               end
            end
            GET_ADDR, GET_STRB, GET_DATA: begin
               if (rx_valid) begin
                  idle_cnt <= '0;
                  if (state == GET_ADDR) begin
                     addr_r <= rx_byte[5:0];
                     if (is_read) begin
                        state       <= REQ;
                        bus.bus_req <= 1'b1;
                     end else begin
                        state <= GET_STRB;
                     end
                  end else if (state == GET_STRB) begin
                     strb_r   <= rx_byte[3:0];
                     byte_cnt <= '0;
                     state    <= GET_DATA;
                  end else begin
                     wdata    <= {rx_byte, wdata[31:8]};
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        state       <= REQ;
                        bus.bus_req <= 1'b1;
                     end
                  end
               end else if (idle_cnt == TIMEOUT) begin
                  state <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 20'd1;
               end
            end
            REQ: begin
               if (bus.bus_gnt) begin
                  state    <= ACCESS;
                  bus.cs   <= 1'b1;
                  bus.addr <= addr_r;
                  if (is_read) begin
                     bus.oe <= 1'b1;
                  end else begin
                     bus.wstrb    <= strb_r;
                     bus.data_out <= wdata;
                  end
               end
            end
            ACCESS: begin
               bus.cs      <= 1'b0;
               bus.oe      <= 1'b0;
               bus.wstrb   <= '0;
               bus.bus_req <= 1'b0;
               if (is_read) begin
                  resp_word <= bus.data_in;
                  byte_cnt  <= 2'd3;
               end else begin
                  resp_word <= 32'h0000_0006;
                  byte_cnt  <= 2'd0;
               end
               state <= RESP;
            end
            RESP: begin
               if (!tx_active && !tx_load) begin
                  tx_load   <= 1'b1;
                  tx_data   <= resp_word[7:0];
                  resp_word <= resp_word >> 8;
                  state     <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               if (tx_done) begin
                  if (byte_cnt == 2'd0) begin
                     state <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt - 2'd1;
                     state    <= RESP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus accesses and TX bytes,
// independent monitors decode cs cycles and the txd line and pop/compare.
module tb_uart_bus_bridge;

   localparam logic [15:0] BRR     = 16'd3;
   localparam int          BIT     = 4;
   localparam int          TMO     = 200;

   typedef struct packed {
      logic        oe;
      logic [3:0]  wstrb;
      logic [5:0]  addr;
      logic [31:0] wdata;
   } acc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic gnt = 1'b1;
   logic txd;

   acc_t       exp_acc[$];
   logic [7:0] exp_tx[$];
   logic [7:0] cmd_q[$];
   int         checks = 0;
   int         errors = 0;
   int         req_rises = 0;
   logic       req_prev = 1'b0;
   acc_t       mon_acc;

   uart_bus_bridge_if bus_if ();

   uart_bus_bridge #(.BRR(BRR), .TIMEOUT(20'(TMO))) dut (
      .clk (clk),
      .rst (rst),
      .rxd (rxd),
      .txd (txd),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] periph(input logic [5:0] a);
      case (a)
         6'd9:    periph = 32'h0000_00A5;
         6'd1:    periph = 32'hCAFE_F00D;
         default: periph = {26'h02B_4000, a};
      endcase
   endfunction

   assign bus_if.data_in = periph(bus_if.addr);
   assign bus_if.bus_gnt = gnt;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic expect_tx(input logic [7:0] b);
      exp_tx.push_back(b);
   endtask

   task automatic expect_acc(input logic oe, input logic [3:0] ws, input logic [5:0] a, input logic [31:0] d);
      acc_t e;
      e.oe = oe; e.wstrb = ws; e.addr = a; e.wdata = d;
      exp_acc.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic applyStimulus();
      while (cmd_q.size() > 0) send_byte(cmd_q.pop_front(), 1'b1);
   endtask

   task automatic wait_quiet(input int bound);
      int n = 0;
      while ((exp_tx.size() != 0 || exp_acc.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      checkOutput("pending_after_wait", 32'(exp_tx.size() + exp_acc.size()), 32'd0);
      exp_tx.delete();
      exp_acc.delete();
      repeat (20) @(negedge clk);
   endtask

   task automatic read_9();
      expect_acc(1'b1, 4'h0, 6'd9, 32'h0);
      expect_tx(8'hA5); expect_tx(8'h00); expect_tx(8'h00); expect_tx(8'h00);
      cmd_q.push_back(8'h52); cmd_q.push_back(8'h09);
      applyStimulus();
      wait_quiet(2000);
   endtask

   // Bus monitor: every cs cycle must match the next queued access.
   always @(negedge clk) begin
      if (bus_if.bus_req && !req_prev) req_rises++;
      req_prev = bus_if.bus_req;
      if (!rst && bus_if.cs === 1'b1) begin
         if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_access: got cs at addr %h expected no access", bus_if.addr);
         end else begin
            mon_acc = exp_acc.pop_front();
            checkOutput("acc_ctrl", 32'({bus_if.oe, bus_if.wstrb, bus_if.addr}),
                        32'({mon_acc.oe, mon_acc.wstrb, mon_acc.addr}));
            if (!mon_acc.oe) checkOutput("acc_wdata", bus_if.data_out, mon_acc.wdata);
         end
      end
   end

   // TX monitor: decodes frames mid-bit; a frame cut by reset is dropped.
   initial begin : tx_mon
      logic [7:0] b;
      logic       stop_v;
      logic       aborted;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst && txd === 1'b0) begin
            aborted = 1'b0;
            b = '0;
            repeat (2) begin @(negedge clk); if (rst) aborted = 1'b1; end
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) begin @(negedge clk); if (rst) aborted = 1'b1; end
               b[i] = txd;
            end
            repeat (BIT) begin @(negedge clk); if (rst) aborted = 1'b1; end
            stop_v = txd;
            if (!aborted) begin
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_tx: got byte %h expected none", b);
               end else begin
                  e = exp_tx.pop_front();
                  checkOutput("tx_byte", 32'({stop_v, b}), 32'({1'b1, e}));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: got no end of test expected finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stim
      int bad;
      int r0;
      int n;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_txd", 32'(txd), 32'd1);
      checkOutput("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      checkOutput("rst_cs", 32'(bus_if.cs), 32'd0);
      checkOutput("rst_oe", 32'(bus_if.oe), 32'd0);
      checkOutput("rst_wstrb", 32'(bus_if.wstrb), 32'd0);
      checkOutput("rst_addr", 32'(bus_if.addr), 32'd0);
      checkOutput("rst_data_out", bus_if.data_out, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] read addr 9");
      read_9();

      $display("[TB] write addr 0x0A strobe 0011");
      expect_acc(1'b0, 4'h3, 6'h0A, 32'h0000_1234);
      expect_tx(8'h06);
      cmd_q = '{8'h57, 8'h0A, 8'h03, 8'h34, 8'h12, 8'h00, 8'h00};
      applyStimulus();
      wait_quiet(2000);
      checkOutput("data_out_hold", bus_if.data_out, 32'h0000_1234);

      $display("[TB] no-op write, ignored addr/strobe high bits");
      expect_acc(1'b0, 4'h0, 6'h3F, 32'h1122_3344);
      expect_tx(8'h06);
      cmd_q = '{8'h57, 8'hFF, 8'hF0, 8'h44, 8'h33, 8'h22, 8'h11};
      applyStimulus();
      wait_quiet(2000);

      $display("[TB] grant withheld 1000 cycles");
      gnt = 1'b0;
      expect_acc(1'b1, 4'h0, 6'd1, 32'h0);
      expect_tx(8'h0D); expect_tx(8'hF0); expect_tx(8'hFE); expect_tx(8'hCA);
      cmd_q = '{8'h52, 8'h01};
      applyStimulus();
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (bus_if.bus_req !== 1'b1 || bus_if.cs !== 1'b0) bad++;
      end
      checkOutput("hold_req_no_cs", 32'(bad), 32'd0);
      gnt = 1'b1;
      @(negedge clk);
      checkOutput("grant_access_next", 32'(bus_if.cs), 32'd1);
      wait_quiet(2000);
      checkOutput("req_released", 32'(bus_if.bus_req), 32'd0);

      $display("[TB] unknown command");
      r0 = req_rises;
      expect_tx(8'h15);
      cmd_q = '{8'h41};
      applyStimulus();
      wait_quiet(1000);
      checkOutput("nak_no_req", 32'(req_rises - r0), 32'd0);
      read_9();

      $display("[TB] inter-byte timeout");
      cmd_q = '{8'h57, 8'h00};
      applyStimulus();
      repeat (TMO + 1) @(negedge clk);
      read_9();

      $display("[TB] framing error");
      send_byte(8'h52, 1'b0);
      repeat (20) @(negedge clk);
      read_9();

      $display("[TB] reset during response");
      expect_acc(1'b1, 4'h0, 6'd9, 32'h0);
      cmd_q = '{8'h52, 8'h09};
      applyStimulus();
      n = 0;
      while (txd !== 1'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("resp_started", 32'(txd), 32'd0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_txd", 32'(txd), 32'd1);
      checkOutput("mid_rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      checkOutput("mid_rst_cs", 32'(bus_if.cs), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("acc_before_reset", 32'(exp_acc.size()), 32'd0);
      exp_acc.delete();
      exp_tx.delete();
      repeat (50) @(negedge clk);
      read_9();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 SHALL have parameter BRR, default 16'd433, UART bit period in clocks minus one (bit period = BRR+1 clocks).
REQ-002 SHALL have parameter TIMEOUT, default 20'hFFFFF, inter-byte idle limit in clocks.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rxd  input  1  UART receive line, asynchronous, idle high.
REQ-006 txd  output  1  UART transmit line, idle high.
REQ-007 bus_req  output  1  request for peripheral bus ownership.
REQ-008 bus_gnt  input  1  bus granted; bridge drives bus only while bus_gnt=1.
REQ-009 cs  output  1  peripheral select, one-cycle strobe.
REQ-010 oe  output  1  read enable, qualifies cs.
REQ-011 wstrb  output  4  byte write strobes, qualify cs.
REQ-012 addr  output  6  peripheral register address.
REQ-013 data_out  output  32  write data to peripherals.
REQ-014 data_in  input  32  read data from peripherals, valid combinationally while cs&&oe.

Function
REQ-015 RX SHALL double-flop rxd before use; 8N1, LSB first.
REQ-016 RX SHALL detect start on synchronized falling edge, recheck low at half period ((BRR+1)>>1 clocks), then sample each data and stop bit every BRR+1 clocks.
REQ-017 RX byte with stop bit 0 (framing error) or false start SHALL be discarded silently; RX returns to hunt state.
REQ-018 TX SHALL send 1 start, 8 data LSB-first, 1 stop, each BRR+1 clocks; next byte may start the cycle after stop bit ends.
REQ-019 Command protocol: 'R'(0x52), addr byte -> read; 'W'(0x57), addr byte, strobe byte, 4 data bytes LSB-first -> write.
REQ-020 addr byte bits [5:0] SHALL form addr; bits [7:6] ignored. Strobe byte bits [3:0] SHALL form wstrb; bits [7:4] ignored.
REQ-021 Any other command byte in IDLE SHALL produce single NAK 0x15 and remain in IDLE.
REQ-022 FSM states: IDLE, GET_ADDR, GET_STRB, GET_DATA (4-byte count), REQ, ACCESS, RESP (byte count), WAIT_TX.
REQ-023 After final command byte, FSM SHALL enter REQ and assert bus_req the next cycle, held until ACCESS completes.
REQ-024 In REQ with bus_gnt=1, FSM SHALL enter ACCESS; in ACCESS exactly one cycle with cs=1 and addr valid: read => oe=1, wstrb=0, data_in latched that edge; write => oe=0, wstrb per command, data_out = assembled word.
REQ-025 Write with wstrb=0 SHALL still perform the cs cycle (no-op write) and be acknowledged.
REQ-026 bus_req SHALL deassert the cycle after ACCESS; cs, oe, wstrb SHALL be 0 in every other state.
REQ-027 Responses: read => 4 bytes data_in latched, LSB first; write => single ACK 0x06.
REQ-028 RX bytes arriving during REQ, ACCESS, RESP, WAIT_TX SHALL be discarded; FSM returns to IDLE only after last response stop bit.
REQ-029 In GET_ADDR, GET_STRB, GET_DATA an idle counter SHALL reset per received byte; reaching TIMEOUT SHALL abort to IDLE without bus access or response.
REQ-030 bus_gnt may stay low indefinitely; no timeout applies in REQ.
REQ-031 data_out and addr SHALL hold their last values outside ACCESS.

Reset
REQ-032 While rst=1 at a clock edge: txd=1, bus_req=0, cs=0, oe=0, wstrb=0, addr=0, data_out=0, FSM=IDLE, RX hunting, TX idle, all counters 0.
REQ-033 rst mid-frame or mid-access SHALL abandon the transaction; the partial TX frame is truncated with txd high the cycle after reset.
REQ-034 Synchronizer flops SHALL reset to 1.

Verification
REQ-035 BRR=3: send 'R',0x09; peripheral returns 0xA5 on addr 9, bus_gnt=1 -> one cs&&oe cycle at addr 9, txd bytes A5,00,00,00.
REQ-036 Send 'W',0x0A,0x03,0x34,0x12,0x00,0x00 -> one cs cycle, wstrb=0011, addr=0x0A, data_out=0x00001234, txd byte 0x06.
REQ-037 bus_gnt held low 1000 cycles after 'R',0x01 -> bus_req high, cs low throughout; grant -> access next cycle, response follows.
REQ-038 Send 0x41 -> txd 0x15, no bus_req; then valid read completes normally.
REQ-039 Send 'W',0x00 then idle TIMEOUT+1 clocks -> no cs, no txd activity; next 'R' decoded as new command.
REQ-040 Send 'R' with stop bit forced 0 -> byte discarded, no response; assert rst during RESP -> txd=1, bus_req=0 next cycle.
